window_scan_control: RTL and testbench

WINDOW_SCAN_CONTROL -- requirements
Module: window_scan_control

---
 rtl/window_scan_control.sv | 216 +++++++++++++++++++++
 tb/tb_window_scan_control.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_scan_control.sv
// window_scan_control
//   Walks a processing window across an image, skipping a MARGIN-pixel
//   border. It keeps the read/write pixel addresses of the window centre
//   consistent with the centre coordinates (x, y). The scan moves one
//   position per accepted step request, and the scan order is serpentine
//   or raster.
//
//   Optional feature macro: SCAN_RASTER_MODE_EN
//     defined   -> the mode input (sampled at load) selects raster (1) or
//                  serpentine (0) order
//     undefined -> serpentine order only; mode is ignored
//
// Ports
//   clk, n_reset              clock (rising edge), async active-low reset
//   cfg_cols, cfg_rows        image dimensions (cfg_cols is the row stride)
//   base_addr_r, base_addr_w  read / write image base addresses
//   load                      capture the configuration and park the window
//                             at its start position
//   step_req                  advance one window position
//   mode                      0 = serpentine, 1 = raster
//   addr_r, addr_w            current read / write addresses
//   x, y                      current window-centre coordinates
//   direction                 last move: 00 none, 01 right, 10 left, 11 down
//   step_ack, load_done       one-cycle completion pulses
//   all_done                  scan finished (level)
//   busy                      a step is in flight
//   cfg_err                   last load was rejected (level)
module window_scan_control #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 12,
  parameter int MARGIN = 1
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [DIM_W-1:0]  cfg_cols,
  input  logic [DIM_W-1:0]  cfg_rows,
  input  logic [ADDR_W-1:0] base_addr_r,
  input  logic [ADDR_W-1:0] base_addr_w,
  input  logic              load,
  input  logic              step_req,
  input  logic              mode,
  output logic [ADDR_W-1:0] addr_r,
  output logic [ADDR_W-1:0] addr_w,
  output logic [DIM_W-1:0]  x,
  output logic [DIM_W-1:0]  y,
  output logic [1:0]        direction,
  output logic              step_ack,
  output logic              load_done,
  output logic              all_done,
  output logic              busy,
  output logic              cfg_err
);

  localparam logic [DIM_W-1:0]  MARGIN_D = DIM_W'(MARGIN);
  localparam logic [DIM_W-1:0]  MIN_DIM  = DIM_W'(2 * MARGIN + 1);
  localparam logic [ADDR_W-1:0] MARGIN_A = ADDR_W'(MARGIN);
  localparam logic [ADDR_W-1:0] WRAP_A   = ADDR_W'(2 * MARGIN + 1);

  typedef enum logic [1:0] {IDLE, READY, STEP, DONE} state_t;

  state_t            state, state_n;
  logic [DIM_W-1:0]  cols_q, cols_n;
  logic [DIM_W-1:0]  rows_q, rows_n;
  logic              heading_left, heading_left_n;
  logic [ADDR_W-1:0] addr_r_n, addr_w_n;
  logic [DIM_W-1:0]  x_n, y_n;
  logic [1:0]        direction_n;
  logic              step_ack_n, load_done_n, all_done_n, busy_n, cfg_err_n;

  logic [DIM_W-1:0]  last_col, last_row;
  logic [ADDR_W-1:0] cols_a, start_offset;
  logic              at_row_end;

`ifdef SCAN_RASTER_MODE_EN
  logic raster_q, raster_n;
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  assign last_col     = cols_q - 1'b1 - MARGIN_D;
  assign last_row     = rows_q - 1'b1 - MARGIN_D;
  assign cols_a       = ADDR_W'(cols_q);
  // Offset of the first centre (MARGIN, MARGIN) from the image base.
  assign start_offset = ADDR_W'(cfg_cols) * MARGIN_A + MARGIN_A;
  // Raster never turns left, so heading_left stays 0 in that mode.
  assign at_row_end   = heading_left ? (x == MARGIN_D) : (x == last_col);

  always_comb begin
    state_n        = state;
    cols_n         = cols_q;
    rows_n         = rows_q;
    heading_left_n = heading_left;
    addr_r_n       = addr_r;
    addr_w_n       = addr_w;
    x_n            = x;
    y_n            = y;
    direction_n    = direction;
    step_ack_n     = 1'b0;
    load_done_n    = 1'b0;
    all_done_n     = all_done;
    cfg_err_n      = cfg_err;
`ifdef SCAN_RASTER_MODE_EN
    raster_n       = raster_q;
`endif

    if (load) begin
      if (cfg_cols < MIN_DIM || cfg_rows < MIN_DIM) begin
        cfg_err_n = 1'b1;
        state_n   = IDLE;
      end else begin
        cols_n         = cfg_cols;
        rows_n         = cfg_rows;
`ifdef SCAN_RASTER_MODE_EN
        raster_n       = mode;
`endif
        x_n            = MARGIN_D;
        y_n            = MARGIN_D;
        addr_r_n       = base_addr_r + start_offset;
        addr_w_n       = base_addr_w + start_offset;
        direction_n    = 2'b00;
        heading_left_n = 1'b0;
        all_done_n     = 1'b0;
        cfg_err_n      = 1'b0;
        load_done_n    = 1'b1;
        state_n        = READY;
      end
    end else begin
      case (state)
        READY: begin
          if (step_req) begin
            step_ack_n = 1'b1;
            if (y == last_row && at_row_end) begin
              // Final position: the window stays put and the scan closes.
              all_done_n = 1'b1;
              state_n    = DONE;
            end else begin
              state_n = STEP;
              if (!heading_left && x < last_col) begin
                x_n         = x + 1'b1;
                addr_r_n    = addr_r + 1'b1;
                addr_w_n    = addr_w + 1'b1;
                direction_n = 2'b01;
              end else if (heading_left && x > MARGIN_D) begin
                x_n         = x - 1'b1;
                addr_r_n    = addr_r - 1'b1;
                addr_w_n    = addr_w - 1'b1;
                direction_n = 2'b10;
`ifdef SCAN_RASTER_MODE_EN
              end else if (raster_q) begin
                // Jump from the last column back to the first one on the next row.
                x_n         = MARGIN_D;
                y_n         = y + 1'b1;
                addr_r_n    = addr_r + WRAP_A;
                addr_w_n    = addr_w + WRAP_A;
                direction_n = 2'b11;
`endif
              end else begin
                y_n            = y + 1'b1;
                addr_r_n       = addr_r + cols_a;
                addr_w_n       = addr_w + cols_a;
                direction_n    = 2'b11;
                heading_left_n = ~heading_left;
              end
            end
          end
        end
        STEP:    state_n = READY;
        default: ;
      endcase
    end

    busy_n = (state_n == STEP);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= IDLE;
      cols_q       <= '0;
      rows_q       <= '0;
      heading_left <= 1'b0;
      addr_r       <= '0;
      addr_w       <= '0;
      x            <= '0;
      y            <= '0;
      direction    <= 2'b00;
      step_ack     <= 1'b0;
      load_done    <= 1'b0;
      all_done     <= 1'b0;
      busy         <= 1'b0;
      cfg_err      <= 1'b0;
`ifdef SCAN_RASTER_MODE_EN
      raster_q     <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      cols_q       <= cols_n;
      rows_q       <= rows_n;
      heading_left <= heading_left_n;
      addr_r       <= addr_r_n;
      addr_w       <= addr_w_n;
      x            <= x_n;
      y            <= y_n;
      direction    <= direction_n;
      step_ack     <= step_ack_n;
      load_done    <= load_done_n;
      all_done     <= all_done_n;
      busy         <= busy_n;
      cfg_err      <= cfg_err_n;
`ifdef SCAN_RASTER_MODE_EN
      raster_q     <= raster_n;
`endif
    end
  end

endmodule

// File: tb/tb_window_scan_control.sv
// tb_window_scan_control
//   Self-checking bench for window_scan_control (default parameters).
//   A reference model predicts every window position. Each accepted step
//   pushes its prediction onto a queue, and the entry is popped and
//   compared when the DUT answers with step_ack.
module tb_window_scan_control;

  localparam int AW = 16;
  localparam int DW = 12;
  localparam int M  = 1;

  logic          clk = 1'b0;
  logic          n_reset = 1'b1;
  logic [DW-1:0] cfg_cols = '0, cfg_rows = '0;
  logic [AW-1:0] base_addr_r = '0, base_addr_w = '0;
  logic          load = 1'b0, step_req = 1'b0, mode = 1'b0;
  logic [AW-1:0] addr_r, addr_w;
  logic [DW-1:0] x, y;
  logic [1:0]    direction;
  logic          step_ack, load_done, all_done, busy, cfg_err;

  typedef struct packed {
    logic [AW-1:0] ar;
    logic [AW-1:0] aw;
    logic [DW-1:0] px;
    logic [DW-1:0] py;
    logic [1:0]    dir;
    logic          done;
    logic          bsy;
  } exp_t;

  exp_t q[$];
  exp_t e, obs;
  int   checks = 0;
  int   errors = 0;

  // Reference model state.
  int         m_x, m_y, m_cols, m_rows, m_base_r, m_base_w;
  logic       m_left, m_raster, m_done;
  logic [1:0] m_dir;

  window_scan_control #(.ADDR_W(AW), .DIM_W(DW), .MARGIN(M)) dut (
    .clk(clk), .n_reset(n_reset), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .base_addr_r(base_addr_r), .base_addr_w(base_addr_w), .load(load),
    .step_req(step_req), .mode(mode), .addr_r(addr_r), .addr_w(addr_w),
    .x(x), .y(y), .direction(direction), .step_ack(step_ack),
    .load_done(load_done), .all_done(all_done), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [AW-1:0] model_addr(input int base);
    return AW'(base + m_y * m_cols + m_x);
  endfunction

  task automatic model_load(input int cols, input int rows, input int br, input int bw,
                            input logic raster);
    m_cols = cols; m_rows = rows; m_base_r = br; m_base_w = bw; m_raster = raster;
    m_x = M; m_y = M; m_left = 1'b0; m_dir = 2'b00; m_done = 1'b0;
  endtask

  // Predict the outcome of one accepted step and queue it.
  task automatic model_step_push();
    int   last;
    logic at_end;
    last   = m_cols - 1 - M;
    at_end = m_left ? (m_x == M) : (m_x == last);
    if (m_y == m_rows - 1 - M && at_end) begin
      m_done = 1'b1;
    end else if (!m_left && m_x < last) begin
      m_x = m_x + 1; m_dir = 2'b01;
    end else if (m_left && m_x > M) begin
      m_x = m_x - 1; m_dir = 2'b10;
    end else if (m_raster) begin
      m_x = M; m_y = m_y + 1; m_dir = 2'b11;
    end else begin
      m_y = m_y + 1; m_dir = 2'b11; m_left = ~m_left;
    end
    q.push_back('{ar: model_addr(m_base_r), aw: model_addr(m_base_w), px: DW'(m_x),
                  py: DW'(m_y), dir: m_dir, done: m_done, bsy: ~m_done});
  endtask

  task automatic drive_load(input int cols, input int rows, input int br, input int bw,
                            input logic md, input logic with_step);
    cfg_cols = DW'(cols); cfg_rows = DW'(rows);
    base_addr_r = AW'(br); base_addr_w = AW'(bw);
    mode = md; load = 1'b1; step_req = with_step;
    @(posedge clk); #1;
    load = 1'b0; step_req = 1'b0;
  endtask

  task automatic drive_step();
    step_req = 1'b1;
    @(posedge clk); #1;
    step_req = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 n_reset = 1'b0;
    idle_cycle();
    checks++;
    if ({addr_r, addr_w, x, y, direction, step_ack, load_done, all_done, busy, cfg_err} !== 63'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h %h %h %h %b required all zero", addr_r, addr_w, x, y, direction);
    end
    n_reset = 1'b1;
    idle_cycle();
    drive_step();
    checks++;
    if (step_ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_step_ignored: step_ack=%b busy=%b required 0 0", step_ack, busy);
    end
    idle_cycle();
  endtask

  task automatic test_scan(input string name, input logic md, input logic raster,
                           input logic [6*AW-1:0] tbl);
    drive_load(5, 4, 'h100, 'h200, md, 1'b0);
    model_load(5, 4, 'h100, 'h200, raster);
    checks++;
    if ({load_done, cfg_err, busy, all_done} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL %s_load_flags: got %b required 1000", name, {load_done, cfg_err, busy, all_done});
    end
    checks++;
    if ({addr_r, addr_w, x, y, direction} !== {16'h0106, 16'h0206, 12'd1, 12'd1, 2'b00}) begin
      errors++;
      $display("[TB] FAIL %s_load_pos: got %h %h %0d %0d %b required 0106 0206 1 1 00",
               name, addr_r, addr_w, x, y, direction);
    end
    idle_cycle();
    for (int i = 0; i < 6; i++) begin
      model_step_push();
      drive_step();
      e = q.pop_front();
      checks++;
      if (step_ack !== 1'b1) begin
        errors++;
        $display("[TB] FAIL %s_ack_%0d: got %b required 1", name, i, step_ack);
      end else begin
        obs = {addr_r, addr_w, x, y, direction, all_done, busy};
        checks++;
        if (obs !== e) begin
          errors++;
          $display("[TB] FAIL %s_step_%0d: got %h required %h", name, i, obs, e);
        end
      end
      checks++;
      if (addr_r !== tbl[16*(5-i) +: 16]) begin
        errors++;
        $display("[TB] FAIL %s_addr_seq_%0d: got %h required %h", name, i, addr_r, tbl[16*(5-i) +: 16]);
      end
      idle_cycle();
    end
    drive_step();
    checks++;
    if (step_ack !== 1'b0 || all_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_done_hold: step_ack=%b all_done=%b required 0 1", name, step_ack, all_done);
    end
    idle_cycle();
  endtask

  task automatic test_cfg_err();
    drive_load(2, 8, 'h700, 'h800, 1'b0, 1'b0);
    checks++;
    if ({cfg_err, load_done, busy} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL cfg_err_flags: got %b required 100", {cfg_err, load_done, busy});
    end
    checks++;
    if (addr_r !== model_addr(m_base_r) || addr_w !== model_addr(m_base_w)) begin
      errors++;
      $display("[TB] FAIL cfg_err_addr_kept: got %h %h required %h %h",
               addr_r, addr_w, model_addr(m_base_r), model_addr(m_base_w));
    end
    idle_cycle();
    drive_step();
    checks++;
    if (step_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cfg_err_step_ignored: got %b required 0", step_ack);
    end
    idle_cycle();
    drive_load(8, 2, 'h700, 'h800, 1'b0, 1'b0);
    checks++;
    if ({cfg_err, load_done} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL cfg_err_rows: got %b required 10", {cfg_err, load_done});
    end
    // Smallest legal image: a single window position.
    drive_load(3, 3, 'h700, 'h800, 1'b0, 1'b0);
    model_load(3, 3, 'h700, 'h800, 1'b0);
    checks++;
    if ({cfg_err, load_done, addr_r, addr_w} !== {2'b01, 16'h0704, 16'h0804}) begin
      errors++;
      $display("[TB] FAIL min_load: got %b %h %h required 01 0704 0804", {cfg_err, load_done}, addr_r, addr_w);
    end
    idle_cycle();
    model_step_push();
    drive_step();
    e = q.pop_front();
    obs = {addr_r, addr_w, x, y, direction, all_done, busy};
    checks++;
    if (step_ack !== 1'b1 || obs !== e) begin
      errors++;
      $display("[TB] FAIL min_single_step: ack=%b got %h required %h", step_ack, obs, e);
    end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    drive_load(5, 4, 'h300, 'h400, 1'b0, 1'b0);
    model_load(5, 4, 'h300, 'h400, 1'b0);
    step_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) model_step_push();
      @(posedge clk); #1;
      checks++;
      if (step_ack !== (i % 2 == 0)) begin
        errors++;
        $display("[TB] FAIL b2b_ack_%0d: got %b required %b", i, step_ack, (i % 2 == 0));
      end
      if (step_ack === 1'b1 && q.size() > 0) begin
        e = q.pop_front();
        obs = {addr_r, addr_w, x, y, direction, all_done, busy};
        checks++;
        if (obs !== e) begin
          errors++;
          $display("[TB] FAIL b2b_step_%0d: got %h required %h", i, obs, e);
        end
      end
    end
    step_req = 1'b0;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_queue_empty: got %0d entries required 0", q.size());
    end
    q.delete();
    drive_load(5, 4, 'h500, 'h600, 1'b0, 1'b1);
    model_load(5, 4, 'h500, 'h600, 1'b0);
    checks++;
    if ({load_done, step_ack, busy, x, y, addr_r} !== {3'b100, 12'd1, 12'd1, 16'h0506}) begin
      errors++;
      $display("[TB] FAIL load_priority: got %b %0d %0d %h required 100 1 1 0506",
               {load_done, step_ack, busy}, x, y, addr_r);
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid_scan();
    drive_load(5, 4, 'h100, 'h200, 1'b0, 1'b0);
    idle_cycle();
    drive_step();
    idle_cycle();
    drive_step();
    n_reset = 1'b0;
    #2;
    checks++;
    if ({addr_r, addr_w, x, y, direction, step_ack, load_done, all_done, busy, cfg_err} !== 63'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_scan: got %h %h %h %h %b required all zero", addr_r, addr_w, x, y, direction);
    end
    idle_cycle();
    n_reset = 1'b1;
    idle_cycle();
    drive_step();
    checks++;
    if (step_ack !== 1'b0 || x !== '0) begin
      errors++;
      $display("[TB] FAIL reset_step_ignored: ack=%b x=%0d required 0 0", step_ack, x);
    end
    idle_cycle();
  endtask

  task automatic test_wrap();
    drive_load(20, 5, 'hFFE0, 'h8000, 1'b0, 1'b0);
    model_load(20, 5, 'hFFE0, 'h8000, 1'b0);
    checks++;
    if (addr_r !== 16'hFFF5 || addr_w !== 16'h8015) begin
      errors++;
      $display("[TB] FAIL wrap_load: got %h %h required fff5 8015", addr_r, addr_w);
    end
    idle_cycle();
    for (int i = 0; i < 20; i++) begin
      model_step_push();
      drive_step();
      e = q.pop_front();
      obs = {addr_r, addr_w, x, y, direction, all_done, busy};
      checks++;
      if (step_ack !== 1'b1 || obs !== e) begin
        errors++;
        $display("[TB] FAIL wrap_step_%0d: ack=%b got %h required %h", i, step_ack, obs, e);
      end
      idle_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_scan("serpentine", 1'b0, 1'b0,
              {16'h0107, 16'h0108, 16'h010D, 16'h010C, 16'h010B, 16'h010B});
`ifdef SCAN_RASTER_MODE_EN
    test_scan("raster", 1'b1, 1'b1,
              {16'h0107, 16'h0108, 16'h010B, 16'h010C, 16'h010D, 16'h010D});
`else
    test_scan("mode_ignored", 1'b1, 1'b0,
              {16'h0107, 16'h0108, 16'h010D, 16'h010C, 16'h010B, 16'h010B});
`endif
    test_cfg_err();
    test_back_to_back();
    test_reset_mid_scan();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
